// File: rtl/inelastic_arbiter.sv
// Two-requester round-robin arbiter feeding one shared output register.
// Requesters are accepted only when the register is empty or draining this cycle.
module inelastic_arbiter #(
  parameter int width_p          = 8,
  parameter bit datapath_reset_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               a_valid_i,
  input  logic [width_p-1:0] a_data_i,
  output logic               a_ready_o,
  input  logic               b_valid_i,
  input  logic [width_p-1:0] b_data_i,
  output logic               b_ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  output logic               src_o,
  input  logic               ready_i
);

  logic               valid_q, valid_d;
  logic               src_q, src_d;
  logic               prio_q, prio_d;
  logic [width_p-1:0] data_q, data_d;
  logic               space_s;
  logic               grant_valid_s;
  logic               grant_id_s;
  logic               load_s;

  // Grant selection; prio only matters when both requesters compete.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    case ({a_valid_i, b_valid_i})
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b0;
      end
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b1;
      end
      2'b11: begin
        grant_valid_s = 1'b1;
        grant_id_s    = prio_q;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
      end
    endcase
  end

  // Readies are masked by reset so no handshake can complete while it is held.
  always_comb begin
    space_s   = ~valid_q | ready_i;
    load_s    = space_s & grant_valid_s & ~reset_i;
    a_ready_o = load_s & ~grant_id_s;
    b_ready_o = load_s & grant_id_s;
    data_d    = grant_id_s ? b_data_i : a_data_i;
  end

  // Next-state for valid, source and round-robin pointer.
  always_comb begin
    valid_d = valid_q;
    src_d   = src_q;
    prio_d  = prio_q;
    if (load_s) begin
      valid_d = 1'b1;
      src_d   = grant_id_s;
      if (a_valid_i && b_valid_i) begin
        prio_d = ~grant_id_s;
      end else begin
        prio_d = prio_q;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
      prio_q  <= prio_d;
    end
  end

  if (datapath_reset_p) begin : g_data_rst
    // Shared data register, cleared by reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        data_q <= {width_p{1'b0}};
      end else if (load_s) begin
        data_q <= data_d;
      end
    end
  end else begin : g_data_norst
    // Shared data register without reset.
    always_ff @(posedge clk_i) begin
      if (load_s) begin
        data_q <= data_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign src_o   = src_q;
  assign data_o  = data_q;

endmodule
